// File: rtl/xilinx_sram_mp_if.sv
// Per-port request/response bundle of the multi-port SRAM macro.
// The master drives requests; the memory (slave) returns read data and valid strobes.
interface xilinx_sram_mp_if #(
  parameter int unsigned NumPorts  = 2,
  parameter int unsigned AddrWidth = 10,
  parameter int unsigned DataWidth = 128,
  parameter int unsigned BeWidth   = 16
);
  logic [NumPorts-1:0]                req_i;
  logic [NumPorts-1:0]                we_i;
  logic [NumPorts-1:0][AddrWidth-1:0] addr_i;
  logic [NumPorts-1:0][DataWidth-1:0] wdata_i;
  logic [NumPorts-1:0][BeWidth-1:0]   be_i;
  logic [NumPorts-1:0][DataWidth-1:0] rdata_o;
  logic [NumPorts-1:0]                rvalid_o;

  modport master (output req_i, we_i, addr_i, wdata_i, be_i, input rdata_o, rvalid_o);
  modport slave  (input req_i, we_i, addr_i, wdata_i, be_i, output rdata_o, rvalid_o);
endinterface

// File: rtl/xilinx_sram_mp.sv
// Parametrised one/two-port inferable SRAM with byte enables, a configurable read
// pipeline with per-port valid strobes, and selectable cross-port read-during-write.
module xilinx_sram_mp #(
  parameter int unsigned NumWords   = 1024,
  parameter int unsigned DataWidth  = 128,
  parameter int unsigned ByteWidth  = 8,
  parameter int unsigned NumPorts   = 2,
  parameter int unsigned Latency    = 1,
  parameter bit          WriteFirst = 1'b0,
  parameter              SimInit    = "zeros",
  localparam int unsigned AddrWidth = (NumWords > 32'd1) ? $clog2(NumWords) : 32'd1,
  localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 32'd1) / ByteWidth
) (
  input logic             clk_i,
  input logic             rst_ni,
  xilinx_sram_mp_if.slave bus
);

  // The array stores data XOR InitWord, so zero-initialised storage reads back as
  // InitWord; this gives the "ones" fill without needing an initialiser on the array.
  localparam logic [DataWidth-1:0] InitWord =
      (SimInit == "ones") ? {DataWidth{1'b1}} : {DataWidth{1'b0}};

  localparam bit WidthsOk =
      ($bits(bus.req_i)    == NumPorts) &&
      ($bits(bus.we_i)     == NumPorts) &&
      ($bits(bus.addr_i)   == NumPorts * AddrWidth) &&
      ($bits(bus.wdata_i)  == NumPorts * DataWidth) &&
      ($bits(bus.be_i)     == NumPorts * BeWidth) &&
      ($bits(bus.rdata_o)  == NumPorts * DataWidth) &&
      ($bits(bus.rvalid_o) == NumPorts);

  logic [DataWidth-1:0] mem_r [NumWords];

  logic [NumPorts-1:0]                rng_s;
  logic [NumPorts-1:0]                wr_s;
  logic [NumPorts-1:0]                rd_s;
  logic [NumPorts-1:0]                coll_s;
  logic [NumPorts-1:0][DataWidth-1:0] wmask_s;
  logic [NumPorts-1:0][DataWidth-1:0] oth_mask_s;
  logic [NumPorts-1:0][DataWidth-1:0] oth_data_s;
  logic [NumPorts-1:0][DataWidth-1:0] base_s;
  logic [NumPorts-1:0][DataWidth-1:0] rd_data_s;

  logic [DataWidth-1:0] pipe_data_r [NumPorts][Latency];
  logic [Latency-1:0]   pipe_vld_r  [NumPorts];

  // Request decode and bit-level write masks from the byte enables
  always_comb begin
    rng_s   = '0;
    wr_s    = '0;
    rd_s    = '0;
    wmask_s = '0;
    for (int p = 0; p < NumPorts; p++) begin
      rng_s[p] = 32'(bus.addr_i[p]) < NumWords;
      wr_s[p]  = bus.req_i[p] & bus.we_i[p] & rng_s[p];
      rd_s[p]  = bus.req_i[p] & ~bus.we_i[p];
      for (int i = 0; i < DataWidth; i++) begin
        wmask_s[p][i] = bus.be_i[p][i / ByteWidth];
      end
    end
  end

  if (NumPorts == 32'd2) begin : g_cross
    assign coll_s[0]     = wr_s[1] && (bus.addr_i[1] == bus.addr_i[0]);
    assign coll_s[1]     = wr_s[0] && (bus.addr_i[0] == bus.addr_i[1]);
    assign oth_mask_s[0] = wmask_s[1];
    assign oth_mask_s[1] = wmask_s[0];
    assign oth_data_s[0] = bus.wdata_i[1];
    assign oth_data_s[1] = bus.wdata_i[0];
  end else begin : g_single
    assign coll_s     = '0;
    assign oth_mask_s = '0;
    assign oth_data_s = '0;
  end

  // Array read with out-of-range zeroing and optional write-first forwarding
  always_comb begin
    base_s    = '0;
    rd_data_s = '0;
    for (int p = 0; p < NumPorts; p++) begin
      if (rng_s[p]) begin
        base_s[p] = mem_r[bus.addr_i[p]] ^ InitWord;
      end else begin
        base_s[p] = '0;
      end
      rd_data_s[p] = (WriteFirst && coll_s[p])
          ? ((base_s[p] & ~oth_mask_s[p]) | (oth_data_s[p] & oth_mask_s[p]))
          : base_s[p];
    end
  end

  // Array write: port 1 is applied last, so it owns any byte both ports enable
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NumPorts; p++) begin
      for (int i = 0; i < DataWidth; i++) begin
        if (wr_s[p] && wmask_s[p][i]) begin
          mem_r[bus.addr_i[p]][i] <= bus.wdata_i[p][i] ^ InitWord[i];
        end
      end
    end
  end

  // Read pipeline: each stage loads data only when its incoming valid is set
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int p = 0; p < NumPorts; p++) begin
        pipe_vld_r[p] <= '0;
        for (int s = 0; s < Latency; s++) begin
          pipe_data_r[p][s] <= '0;
        end
      end
    end else begin
      for (int p = 0; p < NumPorts; p++) begin
        pipe_vld_r[p][0] <= rd_s[p];
        if (rd_s[p]) begin
          pipe_data_r[p][0] <= rd_data_s[p];
        end
        for (int s = 1; s < Latency; s++) begin
          pipe_vld_r[p][s] <= pipe_vld_r[p][s-1];
          if (pipe_vld_r[p][s-1]) begin
            pipe_data_r[p][s] <= pipe_data_r[p][s-1];
          end
        end
      end
    end
  end

  // Outputs come straight from the last pipeline stage
  always_comb begin
    bus.rdata_o  = '0;
    bus.rvalid_o = '0;
    for (int p = 0; p < NumPorts; p++) begin
      bus.rdata_o[p]  = pipe_data_r[p][Latency-1];
      bus.rvalid_o[p] = pipe_vld_r[p][Latency-1];
    end
  end

  xilinx_sram_mp_chk #(
    .NumWords  (NumWords),
    .ByteWidth (ByteWidth),
    .NumPorts  (NumPorts),
    .Latency   (Latency),
    .SimInit   (SimInit),
    .AddrWidth (AddrWidth),
    .WidthsOk  (WidthsOk)
  ) u_chk (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req_i  (bus.req_i),
    .addr_i (bus.addr_i)
  );

endmodule

// Simulation-only configuration checks and out-of-range access warnings.
module xilinx_sram_mp_chk #(
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned NumPorts  = 2,
  parameter int unsigned Latency   = 1,
  parameter              SimInit   = "zeros",
  parameter int unsigned AddrWidth = 10,
  parameter bit          WidthsOk  = 1'b1
) (
  input logic                               clk_i,
  input logic                               rst_ni,
  input logic [NumPorts-1:0]                req_i,
  input logic [NumPorts-1:0][AddrWidth-1:0] addr_i
);

  if (NumPorts != 32'd1 && NumPorts != 32'd2) begin : g_err_ports
    $fatal(1, "xilinx_sram_mp: NumPorts must be 1 or 2");
  end
  if (Latency < 32'd1 || Latency > 32'd4) begin : g_err_lat
    $fatal(1, "xilinx_sram_mp: Latency must be 1..4");
  end
  if (ByteWidth != 32'd1 && ByteWidth != 32'd8) begin : g_err_bw
    $fatal(1, "xilinx_sram_mp: ByteWidth must be 1 or 8");
  end
  if (NumWords < 32'd2) begin : g_err_words
    $fatal(1, "xilinx_sram_mp: NumWords must be at least 2");
  end
  if (!(SimInit == "zeros" || SimInit == "ones")) begin : g_err_init
    $fatal(1, "xilinx_sram_mp: SimInit must be zeros or ones");
  end
  if (!WidthsOk) begin : g_err_width
    $fatal(1, "xilinx_sram_mp: bus widths do not match the configuration");
  end

  // Warn about accesses beyond the populated depth
  always @(posedge clk_i) begin
    for (int p = 0; p < NumPorts; p++) begin
      if (rst_ni && req_i[p] && (32'(addr_i[p]) >= NumWords)) begin
        $warning("xilinx_sram_mp: port %0d accessed out-of-range address %0d", p, addr_i[p]);
      end
    end
  end

endmodule
